// File: rtl/cdc_pkg.sv
// Shared types and sizing helpers for the CDC transmit-side controller.
package cdc_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        IDLE   = 2'd1,
        REQ    = 2'd2,
        REL    = 2'd3
    } cdc_tx_state_t;

    localparam int DEFAULT_TIMEOUT = 1024;
    localparam int DEFAULT_GUARD   = 8;

    // Bits needed for a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cdc_tx_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr_i.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         grant_o
);

    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] req_hi;
    logic [NREQ-1:0] pick;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
        assign hi_mask[gi] = (ptr_i <= PW'(gi));
    end

    // Requests at or above the pointer take priority; otherwise wrap to the bottom.
    assign req_hi  = req_i & hi_mask;
    assign pick    = (|req_hi) ? req_hi : req_i;
    assign grant_o = pick & (~pick + NREQ'(1));

endmodule

// File: rtl/cdc_tx_arbiter.sv
// Source-domain transmit controller for a four-phase req/ack CDC channel with
// round-robin arbitration, timeout recovery and a post-reset settle phase.
module cdc_tx_arbiter
    import cdc_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int GUARD   = DEFAULT_GUARD
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [DW-1:0]           xfer_data,
    output logic                    xfer_req,
    input  logic                    xfer_ack_sync,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = cnt_width(TIMEOUT);
    localparam int GW = cnt_width(GUARD);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);

    cdc_tx_state_t   state_q;
    logic [GW-1:0]   guard_cnt_q;
    logic [TW-1:0]   to_cnt_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   rr_ptr_d;
    logic [IW-1:0]   grant_id_q;
    logic [DW-1:0]   xfer_data_q;
    logic            xfer_req_q;
    logic            done_q;
    logic            timeout_err_q;

    logic [NREQ-1:0] grant;
    logic            any_grant;
    logic [IW-1:0]   win_idx;
    logic [DW-1:0]   req_word [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign req_word[gi] = req_data[gi*DW +: DW];
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant)
    );

    assign any_grant = |grant;

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) win_idx = IW'(k);
        end
    end

    assign rr_ptr_d = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= SETTLE;
            guard_cnt_q   <= '0;
            to_cnt_q      <= '0;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            xfer_data_q   <= '0;
            xfer_req_q    <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            unique case (state_q)
                SETTLE: begin
                    // A stale far-side ack must be seen low for GUARD straight cycles.
                    if (xfer_ack_sync) begin
                        guard_cnt_q <= '0;
                    end else if (guard_cnt_q == GUARD_LAST) begin
                        guard_cnt_q <= '0;
                        state_q     <= IDLE;
                    end else begin
                        guard_cnt_q <= guard_cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (any_grant) begin
                        xfer_data_q <= req_word[win_idx];
                        grant_id_q  <= win_idx;
                        xfer_req_q  <= 1'b1;
                        rr_ptr_q    <= rr_ptr_d;
                        to_cnt_q    <= '0;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (xfer_ack_sync) begin
                        xfer_req_q <= 1'b0;
                        to_cnt_q   <= '0;
                        state_q    <= REL;
                    end else if (to_cnt_q == TO_LAST) begin
                        timeout_err_q <= 1'b1;
                        xfer_req_q    <= 1'b0;
                        to_cnt_q      <= '0;
                        guard_cnt_q   <= '0;
                        state_q       <= SETTLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                REL: begin
                    if (!xfer_ack_sync) begin
                        done_q   <= 1'b1;
                        to_cnt_q <= '0;
                        state_q  <= IDLE;
                    end else if (to_cnt_q == TO_LAST) begin
                        timeout_err_q <= 1'b1;
                        xfer_req_q    <= 1'b0;
                        to_cnt_q      <= '0;
                        guard_cnt_q   <= '0;
                        state_q       <= SETTLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= SETTLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE) ? grant : '0;
    assign busy        = (state_q != IDLE);
    assign xfer_data   = xfer_data_q;
    assign xfer_req    = xfer_req_q;
    assign grant_id    = grant_id_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Directed bench for cdc_tx_arbiter with a three-cycle far-side ack model.
module tb_cdc_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;
    localparam int GUARD   = 8;

    logic                 clk       = 1'b0;
    logic                 reset_n   = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*DW-1:0]   req_data  = '0;
    logic [NREQ-1:0]      req_ready;
    logic [DW-1:0]        xfer_data;
    logic                 xfer_req;
    logic                 xfer_ack_sync;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 done;
    logic                 timeout_err;

    // ack_mode: 0 = far-side model (3-cycle echo of xfer_req), 1 = held low, 2 = held high
    int                   ack_mode = 1;
    logic [2:0]           dly      = '0;
    int                   n_checks = 0;
    int                   n_pass   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) dly <= {dly[1:0], xfer_req};

    assign xfer_ack_sync = (ack_mode == 0) ? dly[2] : (ack_mode == 2);

    cdc_tx_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TIMEOUT (TIMEOUT),
        .GUARD   (GUARD)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .xfer_data     (xfer_data),
        .xfer_req      (xfer_req),
        .xfer_ack_sync (xfer_ack_sync),
        .grant_id      (grant_id),
        .busy          (busy),
        .done          (done),
        .timeout_err   (timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges until busy drops; -1 if the budget runs out.
    task automatic count_to_idle(input int budget, output int cnt);
        cnt = 0;
        while (busy) begin
            if (cnt >= budget) begin
                cnt = -1;
                break;
            end
            tick();
            cnt++;
        end
    endtask

    task automatic test_reset();
        int cnt;
        reset_n = 1'b0; req_valid = '0; ack_mode = 1;
        repeat (2) @(posedge clk);
        #1; req_valid = 4'b1111; #1;
        n_checks++; if (xfer_req !== 1'b0) $display("FAIL rst_xfer_req: got %b expected 0", xfer_req); else n_pass++;
        n_checks++; if (xfer_data !== 32'h0) $display("FAIL rst_xfer_data: got %h expected 00000000", xfer_data); else n_pass++;
        n_checks++; if (grant_id !== 2'd0) $display("FAIL rst_grant_id: got %0d expected 0", grant_id); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b expected 1", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %b expected 0", timeout_err); else n_pass++;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL rst_req_ready: got %b expected 0000", req_ready); else n_pass++;
        req_valid = '0;
        @(negedge clk); reset_n = 1'b1;
        count_to_idle(40, cnt);
        n_checks++; if (cnt !== GUARD) $display("FAIL settle_len: got %0d cycles expected %0d", cnt, GUARD); else n_pass++;
        $display("test_reset: settle took %0d cycles", cnt);

        reset_n = 1'b0; #1;
        @(negedge clk); reset_n = 1'b1;
        repeat (5) tick();
        ack_mode = 2; tick(); ack_mode = 1;
        n_checks++; if (busy !== 1'b1) $display("FAIL settle_restart_busy: got %b expected 1", busy); else n_pass++;
        count_to_idle(40, cnt);
        n_checks++; if (cnt !== GUARD) $display("FAIL settle_restart_len: got %0d cycles expected %0d", cnt, GUARD); else n_pass++;
        $display("test_reset: settle after ack glitch took %0d more cycles", cnt);
    endtask

    task automatic test_single();
        int ack_rise, req_fall, done_at, done_cnt, unstable, ready_busy;
        logic busy_at_done;
        ack_mode = 0;
        @(negedge clk);
        req_data  = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0000};
        req_valid = 4'b0100; #1;
        n_checks++; if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b expected 0100", req_ready); else n_pass++;
        tick();
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL single_ready_one_cycle: got %b expected 0000", req_ready); else n_pass++;
        req_valid = '0;
        n_checks++; if (xfer_req !== 1'b1) $display("FAIL single_xfer_req: got %b expected 1", xfer_req); else n_pass++;
        n_checks++; if (xfer_data !== 32'hDEAD_BEEF) $display("FAIL single_xfer_data: got %h expected deadbeef", xfer_data); else n_pass++;
        n_checks++; if (grant_id !== 2'd2) $display("FAIL single_grant_id: got %0d expected 2", grant_id); else n_pass++;
        ack_rise = -1; req_fall = -1; done_at = -1; done_cnt = 0; unstable = 0; ready_busy = 0; busy_at_done = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (xfer_ack_sync && ack_rise < 0) ack_rise = k;
            if (!xfer_req && req_fall < 0) req_fall = k;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin done_at = k; busy_at_done = busy; end
            end
            if (busy && (xfer_data !== 32'hDEAD_BEEF || grant_id !== 2'd2)) unstable++;
            if (busy && req_ready !== 4'b0000) ready_busy++;
        end
        n_checks++; if (ack_rise !== 3) $display("FAIL single_ack_rise: got cycle %0d expected 3", ack_rise); else n_pass++;
        n_checks++; if (req_fall !== 4) $display("FAIL single_req_fall: got cycle %0d expected 4", req_fall); else n_pass++;
        n_checks++; if (done_at !== 8) $display("FAIL single_done_cycle: got cycle %0d expected 8", done_at); else n_pass++;
        n_checks++; if (done_cnt !== 1) $display("FAIL single_done_count: got %0d expected 1", done_cnt); else n_pass++;
        n_checks++; if (busy_at_done !== 1'b0) $display("FAIL single_busy_at_done: got %b expected 0", busy_at_done); else n_pass++;
        n_checks++; if (unstable !== 0) $display("FAIL single_hold_stable: got %0d unstable cycles expected 0", unstable); else n_pass++;
        n_checks++; if (ready_busy !== 0) $display("FAIL single_ready_while_busy: got %0d expected 0", ready_busy); else n_pass++;
        $display("test_single: ack@%0d req_fall@%0d done@%0d pulses=%0d", ack_rise, req_fall, done_at, done_cnt);
    endtask

    task automatic test_round_robin();
        int          cnt, n_acc, cyc, ready_busy;
        int          exp_ids [5];
        logic [31:0] rr_words [4];
        logic [3:0]  exp_ready;
        exp_ids  = '{0, 1, 2, 3, 0};
        rr_words = '{32'hA0A0_0000, 32'h1B1B_1111, 32'h2C2C_2222, 32'h3D3D_3333};
        reset_n = 1'b0; ack_mode = 1; req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        count_to_idle(40, cnt);
        n_checks++; if (cnt !== GUARD) $display("FAIL rr_settle_len: got %0d expected %0d", cnt, GUARD); else n_pass++;
        ack_mode = 0;
        for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = rr_words[i];
        req_valid = 4'b1111;
        n_acc = 0; cyc = 0; ready_busy = 0;
        while (n_acc < 5 && cyc < 200) begin
            @(negedge clk);
            if (busy && req_ready !== 4'b0000) ready_busy++;
            if (req_ready !== 4'b0000) begin
                exp_ready = 4'b0001 << exp_ids[n_acc];
                n_checks++; if (req_ready !== exp_ready) $display("FAIL rr_ready_%0d: got %b expected %b", n_acc, req_ready, exp_ready); else n_pass++;
                tick();
                n_checks++; if (grant_id !== 2'(exp_ids[n_acc])) $display("FAIL rr_grant_%0d: got %0d expected %0d", n_acc, grant_id, exp_ids[n_acc]); else n_pass++;
                n_checks++; if (xfer_data !== rr_words[exp_ids[n_acc]]) $display("FAIL rr_data_%0d: got %h expected %h", n_acc, xfer_data, rr_words[exp_ids[n_acc]]); else n_pass++;
                $display("test_round_robin: accept %0d grant_id=%0d data=%h", n_acc, grant_id, xfer_data);
                n_acc++;
                if (n_acc == 5) req_valid = '0;
            end
            cyc++;
        end
        n_checks++; if (n_acc !== 5) $display("FAIL rr_accept_count: got %0d expected 5", n_acc); else n_pass++;
        n_checks++; if (ready_busy !== 0) $display("FAIL rr_ready_while_busy: got %0d expected 0", ready_busy); else n_pass++;
        count_to_idle(40, cnt);
        n_checks++; if (cnt < 0) $display("FAIL rr_final_idle: got timeout expected idle"); else n_pass++;
    endtask

    task automatic test_timeout();
        int to_at, done_cnt, cnt;
        logic xreq_at_to, busy_at_to;
        ack_mode = 1;
        @(negedge clk);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        n_checks++; if (xfer_req !== 1'b1) $display("FAIL to_xfer_req_rise: got %b expected 1", xfer_req); else n_pass++;
        to_at = -1; done_cnt = 0; xreq_at_to = 1'b1; busy_at_to = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done) done_cnt++;
            if (timeout_err) begin
                to_at = k; xreq_at_to = xfer_req; busy_at_to = busy;
                break;
            end
        end
        n_checks++; if (to_at !== TIMEOUT) $display("FAIL to_req_cycle: got %0d expected %0d", to_at, TIMEOUT); else n_pass++;
        n_checks++; if (xreq_at_to !== 1'b0) $display("FAIL to_req_xfer_req: got %b expected 0", xreq_at_to); else n_pass++;
        n_checks++; if (busy_at_to !== 1'b1) $display("FAIL to_req_busy: got %b expected 1", busy_at_to); else n_pass++;
        n_checks++; if (done_cnt !== 0) $display("FAIL to_req_no_done: got %0d expected 0", done_cnt); else n_pass++;
        count_to_idle(40, cnt);
        n_checks++; if (cnt !== GUARD) $display("FAIL to_req_settle: got %0d expected %0d", cnt, GUARD); else n_pass++;
        $display("test_timeout: timeout_err at cycle %0d, settle %0d", to_at, cnt);
    endtask

    task automatic test_stuck_ack();
        int req_fall, to_at, done_cnt, left, cnt;
        ack_mode = 2;
        @(negedge clk);
        req_valid = 4'b0001; #1;
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL stuck_ready: got %b expected 0001", req_ready); else n_pass++;
        tick();
        req_valid = '0;
        req_fall = -1; to_at = -1; done_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (!xfer_req && req_fall < 0) req_fall = k;
            if (done) done_cnt++;
            if (timeout_err) begin
                to_at = k;
                break;
            end
        end
        n_checks++; if (req_fall !== 1) $display("FAIL stuck_req_fall: got %0d expected 1", req_fall); else n_pass++;
        n_checks++; if (to_at !== TIMEOUT + 1) $display("FAIL stuck_rel_timeout: got %0d expected %0d", to_at, TIMEOUT + 1); else n_pass++;
        n_checks++; if (done_cnt !== 0) $display("FAIL stuck_no_done: got %0d expected 0", done_cnt); else n_pass++;
        left = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (!busy) left++;
        end
        n_checks++; if (left !== 0) $display("FAIL stuck_hold_settle: got %0d idle cycles expected 0", left); else n_pass++;
        ack_mode = 1;
        count_to_idle(40, cnt);
        n_checks++; if (cnt !== GUARD) $display("FAIL stuck_settle_len: got %0d expected %0d", cnt, GUARD); else n_pass++;
        $display("test_stuck_ack: req_fall@%0d timeout@%0d settle %0d", req_fall, to_at, cnt);
    endtask

    task automatic test_reset_mid();
        int waited, early, cnt;
        ack_mode = 0;
        @(negedge clk);
        req_data[2*DW +: DW] = 32'h5A5A_A5A5;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        waited = 0;
        while (!xfer_ack_sync && waited < 10) begin
            tick();
            waited++;
        end
        n_checks++; if (xfer_req !== 1'b1 || xfer_ack_sync !== 1'b1) $display("FAIL mid_pre_reset: got req=%b ack=%b expected 1 1", xfer_req, xfer_ack_sync); else n_pass++;
        ack_mode = 2;
        reset_n = 1'b0; #1;
        n_checks++; if (xfer_req !== 1'b0) $display("FAIL mid_xfer_req_drop: got %b expected 0", xfer_req); else n_pass++;
        n_checks++; if (xfer_data !== 32'h0 || grant_id !== 2'd0) $display("FAIL mid_regs_reset: got %h/%0d expected 00000000/0", xfer_data, grant_id); else n_pass++;
        @(negedge clk); reset_n = 1'b1; req_valid = 4'b1111;
        early = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (req_ready !== 4'b0000 || !busy) early++;
        end
        n_checks++; if (early !== 0) $display("FAIL mid_no_early_grant: got %0d expected 0", early); else n_pass++;
        ack_mode = 1;
        cnt = 0;
        while (req_ready === 4'b0000 && cnt < 40) begin
            tick();
            cnt++;
        end
        n_checks++; if (cnt !== GUARD) $display("FAIL mid_grant_delay: got %0d expected %0d", cnt, GUARD); else n_pass++;
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant: got %b expected 0001", req_ready); else n_pass++;
        $display("test_reset_mid: first grant %0d cycles after ack low, ready=%b", cnt, req_ready);
        @(negedge clk); req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_stuck_ack();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
